// File: rtl/sd_cmd_pkg.sv
// SD-over-SPI command framer shared definitions.
// Frame constants, queue entry layout, FSM states and the CRC7 stepper.
package sd_cmd_pkg;

   localparam logic [6:0] CRC7_POLY  = 7'h09;
   localparam logic [1:0] START_BITS = 2'b01;
   localparam logic       STOP_BIT   = 1'b1;
   localparam int         FRAME_W    = 48;
   localparam int         TOKEN_W    = 40;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CRC,
      ST_PRESENT
   } fr_state_e;

   typedef struct packed {
      logic [5:0]  cmd;
      logic [31:0] arg;
      logic        short_f;
      logic        long_f;
      logic        read_f;
   } cmd_req_t;

   // Shifts the top n bits of data (MSB first) into crc.
   function automatic logic [6:0] crc7_step(
      input logic [6:0] crc,
      input logic [7:0] data,
      input int         n
   );
      logic [6:0] c;
      logic       fb;
      c  = crc;
      fb = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (i < n) begin
            fb = c[6] ^ data[7-i];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ CRC7_POLY;
         end
      end
      return c;
   endfunction

endpackage

// File: rtl/sd_cmd_fifo.sv
// Command request queue for the SD command framer.
// Power-of-two depth, synchronous flush, level counter.
module sd_cmd_fifo #(
   parameter  int DEPTH = 4,
   parameter  int W     = 41,
   localparam int AW    = $clog2(DEPTH),
   localparam int LW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          push,
   input  logic [W-1:0]  din,
   input  logic          pop,
   output logic [W-1:0]  dout,
   output logic [LW-1:0] level,
   output logic          full,
   output logic          empty
);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_q, wr_d;
   logic [AW-1:0] rd_q, rd_d;
   logic [LW-1:0] lvl_q, lvl_d;
   logic          push_ok;
   logic          pop_ok;

   assign full    = (lvl_q == LW'(DEPTH));
   assign empty   = (lvl_q == '0);
   assign level   = lvl_q;
   assign dout    = mem_q[rd_q];
   assign push_ok = push && !full && !flush;
   assign pop_ok  = pop && !empty && !flush;

   // Storage write; contents need no reset since level gates reads.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_q] <= din;
   end

   // Pointer and level update, flush returns to empty.
   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      lvl_d = lvl_q;
      if (flush) begin
         wr_d  = '0;
         rd_d  = '0;
         lvl_d = '0;
      end else begin
         if (push_ok) wr_d = wr_q + 1'b1;
         if (pop_ok)  rd_d = rd_q + 1'b1;
         if (push_ok && !pop_ok)      lvl_d = lvl_q + 1'b1;
         else if (!push_ok && pop_ok) lvl_d = lvl_q - 1'b1;
      end
   end

   // Pointer and level registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         lvl_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         lvl_q <= lvl_d;
      end
   end

endmodule

// File: rtl/sd_cmd_framer.sv
// SD-over-SPI command framer: queue, in-block CRC7, 48-bit frame out.
// IDLE pops a request, CRC walks the token, PRESENT holds the frame.
module sd_cmd_framer
   import sd_cmd_pkg::*;
#(
   parameter  int DEPTH   = 4,
   parameter  int CRC_BPC = 8,
   localparam int LW      = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [5:0]    in_cmd,
   input  logic [31:0]   in_arg,
   input  logic          in_short,
   input  logic          in_long,
   input  logic          in_read,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [47:0]   out_frame,
   output logic          out_short,
   output logic          out_long,
   output logic          out_read,
   output logic [LW-1:0] level,
   output logic          busy
);

   localparam int CRC_CYCLES = TOKEN_W / CRC_BPC;
   localparam int CW         = $clog2(CRC_CYCLES + 1);
   localparam int PW         = $clog2(TOKEN_W + 8);

   fr_state_e            state_q, state_d;
   logic [TOKEN_W-1:0]   tok_q, tok_d;
   logic [6:0]           crc_q, crc_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [FRAME_W-1:0]   frame_q, frame_d;
   logic [2:0]           flg_q, flg_d;

   cmd_req_t             fifo_din;
   cmd_req_t             fifo_dout;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic                 pop;
   logic                 load;
   logic [TOKEN_W+7:0]   tok_pad;
   logic [PW-1:0]        base;
   logic [7:0]           chunk;
   logic [6:0]           crc_nx;

   assign fifo_din  = '{cmd: in_cmd, arg: in_arg, short_f: in_short,
                        long_f: in_long, read_f: in_read};
   assign in_ready  = !fifo_full;
   assign out_valid = (state_q == ST_PRESENT);
   assign busy      = (state_q != ST_IDLE);
   assign out_frame = frame_q;
   assign out_short = flg_q[2];
   assign out_long  = flg_q[1];
   assign out_read  = flg_q[0];

   sd_cmd_fifo #(
      .DEPTH (DEPTH),
      .W     ($bits(cmd_req_t))
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .push  (in_valid && in_ready),
      .din   (fifo_din),
      .pop   (pop),
      .dout  (fifo_dout),
      .level (level),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Pick the next CRC_BPC token bits (padded so the 8-bit window fits).
   always_comb begin
      tok_pad = {tok_q, 8'h00};
      base    = PW'(TOKEN_W + 7 - int'(cnt_q) * CRC_BPC);
      chunk   = tok_pad[base -: 8];
      crc_nx  = crc7_step(crc_q, chunk, CRC_BPC);
   end

   // Framer next-state: load, CRC walk, present and hand off.
   always_comb begin
      state_d = state_q;
      tok_d   = tok_q;
      crc_d   = crc_q;
      cnt_d   = cnt_q;
      frame_d = frame_q;
      flg_d   = flg_q;
      load    = 1'b0;
      pop     = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) load = 1'b1;
         end
         ST_CRC: begin
            crc_d = crc_nx;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(CRC_CYCLES - 1)) begin
               frame_d = {tok_q, crc_nx, STOP_BIT};
               state_d = ST_PRESENT;
            end
         end
         ST_PRESENT: begin
            if (out_ready) begin
               if (!fifo_empty) load = 1'b1;
               else             state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (load) begin
         pop     = 1'b1;
         tok_d   = {START_BITS, fifo_dout.cmd, fifo_dout.arg};
         flg_d   = {fifo_dout.short_f, fifo_dout.long_f, fifo_dout.read_f};
         crc_d   = '0;
         cnt_d   = '0;
         state_d = ST_CRC;
      end
      if (flush) begin
         pop     = 1'b0;
         state_d = ST_IDLE;
      end
   end

   // Framer registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         tok_q   <= '0;
         crc_q   <= '0;
         cnt_q   <= '0;
         frame_q <= '0;
         flg_q   <= '0;
      end else begin
         state_q <= state_d;
         tok_q   <= tok_d;
         crc_q   <= crc_d;
         cnt_q   <= cnt_d;
         frame_q <= frame_d;
         flg_q   <= flg_d;
      end
   end

endmodule
